ccff_bitstream_loader: RTL and testbench

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

---
 rtl/ccff_loader_pkg.sv | 22 ++
 rtl/ccff_bitstream_loader_crc8.sv | 30 +++
 rtl/ccff_bitstream_loader.sv | 177 +++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types, CRC constants and the bit-serial CRC-8 step used by the
// CCFF bitstream loader and its CRC sub-module.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      CHECK  = 2'd3
   } ccff_state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // One MSB-first CRC-8 update for a single input bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic w_fb;
      w_fb      = crc[7] ^ din;
      crc8_step = {crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/ccff_bitstream_loader_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear and update enable.
module ccff_crc8_serial
   import ccff_loader_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   // CRC register: reset/clear to the init value, otherwise fold in one bit when enabled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_crc <= CRC8_INIT;
      end else if (i_clr) begin
         r_crc <= CRC8_INIT;
      end else if (i_en) begin
         r_crc <= crc8_step(r_crc, i_bit);
      end else begin
         r_crc <= r_crc;
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words serially into a CCFF configuration chain, then
// optionally rotates the chain once and compares CRCs of both passes.
module ccff_bitstream_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int VERIFY_EN = 1
)(
   input  logic              prog_clock,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              ccff_tail,
   output logic              ccff_head,
   output logic              config_enable,
   output logic              busy,
   output logic              done,
   output logic              crc_error
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int AV_W  = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [AV_W-1:0]  AV_ZERO   = AV_W'(0);
   localparam logic [AV_W-1:0]  AV_ONE    = AV_W'(1);
   localparam logic [AV_W-1:0]  AV_WORD   = AV_W'(WORD_W - 1);
   localparam logic             VERIFY_ON = (VERIFY_EN != 0);

   ccff_state_e       r_state;
   ccff_state_e       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_shift;     // bits still waiting behind the one on ccff_head
   logic [AV_W-1:0]   r_avail;     // number of valid bits in r_shift
   logic              r_head;
   logic              r_cfg_en;
   logic              r_done;
   logic              r_crc_err;
   logic              w_start_acc;
   logic              w_last_bit;
   logic              w_verify_last;
   logic              w_in_ready;
   logic              w_accept;
   logic [7:0]        w_crc_load;
   logic [7:0]        w_crc_verify;

   assign w_start_acc   = (r_state == IDLE) && start;
   // The bit on ccff_head is the final chain bit: it is shifted at this edge.
   assign w_last_bit    = (r_state == LOAD) && r_cfg_en && (r_cnt == CNT_LAST);
   assign w_verify_last = (r_state == VERIFY) && (r_cnt == CNT_ONE);
   assign w_in_ready    = (r_state == LOAD) && (r_avail == AV_ZERO) && !w_last_bit;
   assign w_accept      = w_in_ready && in_valid;

   // State register.
   always_ff @(posedge prog_clock) begin
      if (!prog_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = LOAD;
            else       w_state_nxt = IDLE;
         end
         LOAD: begin
            if (w_last_bit) w_state_nxt = VERIFY_ON ? VERIFY : IDLE;
            else            w_state_nxt = LOAD;
         end
         VERIFY: begin
            if (w_verify_last) w_state_nxt = CHECK;
            else               w_state_nxt = VERIFY;
         end
         CHECK:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: word shifter, bit counter, registered serial outputs and flags.
   always_ff @(posedge prog_clock) begin
      if (!prog_reset_n) begin
         r_shift   <= '0;
         r_avail   <= AV_ZERO;
         r_cnt     <= '0;
         r_head    <= 1'b0;
         r_cfg_en  <= 1'b0;
         r_done    <= 1'b0;
         r_crc_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cfg_en <= 1'b0;
               if (start) begin
                  r_cnt     <= '0;
                  r_avail   <= AV_ZERO;
                  r_crc_err <= 1'b0;
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            LOAD: begin
               if (w_last_bit) begin
                  // Leftover bits of the current word are dropped here.
                  r_cfg_en <= 1'b0;
                  r_avail  <= AV_ZERO;
                  r_cnt    <= r_cnt + CNT_ONE;
                  r_done   <= ~VERIFY_ON;
               end else begin
                  if (r_cfg_en) r_cnt <= r_cnt + CNT_ONE;
                  else          r_cnt <= r_cnt;
                  if (w_accept) begin
                     r_head   <= in_data[0];
                     r_shift  <= in_data >> 1'b1;
                     r_avail  <= AV_WORD;
                     r_cfg_en <= 1'b1;
                  end else if (r_avail != AV_ZERO) begin
                     r_head   <= r_shift[0];
                     r_shift  <= r_shift >> 1'b1;
                     r_avail  <= r_avail - AV_ONE;
                     r_cfg_en <= 1'b1;
                  end else begin
                     r_cfg_en <= 1'b0;
                  end
               end
            end
            VERIFY: begin
               // Counter arrives at CHAIN_LEN from LOAD and counts down the rotation.
               r_cfg_en <= 1'b0;
               r_cnt    <= r_cnt - CNT_ONE;
               r_done   <= w_verify_last;
            end
            CHECK: begin
               r_cfg_en <= 1'b0;
               if (w_crc_load != w_crc_verify) r_crc_err <= 1'b1;
               else                            r_crc_err <= r_crc_err;
            end
            default: r_cfg_en <= 1'b0;
         endcase
      end
   end

   ccff_crc8_serial u_crc_load (
      .i_clk   (prog_clock),
      .i_rst_n (prog_reset_n),
      .i_clr   (w_start_acc),
      .i_en    ((r_state == LOAD) && r_cfg_en),
      .i_bit   (r_head),
      .o_crc   (w_crc_load)
   );

   ccff_crc8_serial u_crc_verify (
      .i_clk   (prog_clock),
      .i_rst_n (prog_reset_n),
      .i_clr   (w_start_acc),
      .i_en    (r_state == VERIFY),
      .i_bit   (ccff_tail),
      .o_crc   (w_crc_verify)
   );

   // During VERIFY the chain is closed into a ring through the loader.
   assign ccff_head     = (r_state == VERIFY) ? ccff_tail : r_head;
   assign config_enable = (r_state == VERIFY) || r_cfg_en;
   assign in_ready      = w_in_ready;
   assign busy          = (r_state != IDLE);
   assign done          = r_done;
   assign crc_error     = r_crc_err;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: two loaders (5-flop chain without verify, 16-flop chain
// with verify) each driving a behavioural CCFF chain model.
module tb_ccff_bitstream_loader;

   typedef struct packed {
      logic b;     // expected ccff_head
      logic chk;   // also check in_ready on this bit
      logic rdy;   // expected in_ready
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       a_start = 1'b0, a_valid = 1'b0, a_rdy, a_tail, a_head, a_cfg, a_busy, a_done, a_err;
   logic [7:0] a_data = 8'h00;
   logic       b_start = 1'b0, b_valid = 1'b0, b_rdy, b_tail, b_head, b_cfg, b_busy, b_done, b_err;
   logic [7:0] b_data = 8'h00;

   logic [4:0]  chain_a = 5'd0;
   logic [15:0] chain_b = 16'd0;
   int          b_en_cnt = 0;
   int          fault_at = 0;
   logic        fault_arm = 1'b0;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   n_vec = 0, n_err = 0;
   int   a_cfg_cnt = 0, a_done_cnt = 0;
   int   b_cfg_cnt = 0, b_done_cnt = 0, b_gap_cnt = 0;

   always #5 clk = ~clk;

   ccff_bitstream_loader #(.CHAIN_LEN(5), .WORD_W(8), .VERIFY_EN(0)) u_dut_a (
      .prog_clock(clk), .prog_reset_n(rst_n), .start(a_start), .in_data(a_data),
      .in_valid(a_valid), .in_ready(a_rdy), .ccff_tail(a_tail), .ccff_head(a_head),
      .config_enable(a_cfg), .busy(a_busy), .done(a_done), .crc_error(a_err));

   ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8), .VERIFY_EN(1)) u_dut_b (
      .prog_clock(clk), .prog_reset_n(rst_n), .start(b_start), .in_data(b_data),
      .in_valid(b_valid), .in_ready(b_rdy), .ccff_tail(b_tail), .ccff_head(b_head),
      .config_enable(b_cfg), .busy(b_busy), .done(b_done), .crc_error(b_err));

   // Chain models: first shifted bit ends at the tail (highest index).
   always @(posedge clk) begin
      if (a_cfg === 1'b1) chain_a <= {chain_a[3:0], a_head};
   end

   always @(posedge clk) begin
      if (b_cfg === 1'b1) begin
         chain_b  <= {chain_b[14:0], b_head};
         b_en_cnt <= b_en_cnt + 1;
      end
   end

   assign a_tail = chain_a[4];
   // Fault injection: one flop output seen inverted for a single VERIFY cycle.
   assign b_tail = chain_b[15] ^ (fault_arm && (b_en_cnt == fault_at));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_word(input logic is_b, input logic [7:0] w, input int nbits,
                            input logic rdy_last, input logic in_verify);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         e.b   = w[i];
         e.chk = in_verify || (i == 0) || (i == nbits - 1);
         e.rdy = (i == nbits - 1) && !in_verify && rdy_last;
         if (is_b) exp_b.push_back(e);
         else      exp_a.push_back(e);
      end
   endtask

   // Monitor A: pops one expected bit per config_enable cycle.
   initial forever begin
      @(negedge clk);
      if (a_done === 1'b1) a_done_cnt++;
      if (a_cfg === 1'b1) begin
         a_cfg_cnt++;
         if (exp_a.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL a_extra_shift: got config_enable=1, expected 0");
         end else begin
            chk("a_head", 32'(a_head), 32'(exp_a[0].b));
            if (exp_a[0].chk) chk("a_in_ready", 32'(a_rdy), 32'(exp_a[0].rdy));
            exp_a.delete(0);
         end
      end
   end

   // Monitor B: same, plus busy-without-shift cycle count.
   initial forever begin
      @(negedge clk);
      if (b_done === 1'b1) b_done_cnt++;
      if (b_busy === 1'b1 && b_cfg === 1'b0) b_gap_cnt++;
      if (b_cfg === 1'b1) begin
         b_cfg_cnt++;
         if (exp_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_extra_shift: got config_enable=1, expected 0");
         end else begin
            chk("b_head", 32'(b_head), 32'(exp_b[0].b));
            if (exp_b[0].chk) chk("b_in_ready", 32'(b_rdy), 32'(exp_b[0].rdy));
            exp_b.delete(0);
         end
      end
   end

   task automatic pulse_start(input logic is_b);
      if (is_b) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      if (is_b) b_start = 1'b0; else a_start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic send_word(input logic is_b, input logic [7:0] w);
      int t;
      t = 0;
      if (is_b) begin b_data = w; b_valid = 1'b1; end
      else      begin a_data = w; a_valid = 1'b1; end
      while (((is_b ? b_rdy : a_rdy) !== 1'b1) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
      end
      @(negedge clk);
   endtask

   task automatic wait_idle(input logic is_b, input string nm);
      int t;
      t = 0;
      while (((is_b ? b_busy : a_busy) !== 1'b0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: got busy=1 after 200 cycles, expected 0", nm);
      end
      @(negedge clk);
   endtask

   // Full 16-bit load of A5,3C on loader B followed by VERIFY and CHECK.
   task automatic b_full_run(input string nm, input logic with_gap, input logic fault,
                             input logic [15:0] exp_chain, input logic exp_err, input int exp_gap);
      int c0, d0, g0;
      c0 = b_cfg_cnt; d0 = b_done_cnt; g0 = b_gap_cnt;
      push_word(1'b1, 8'hA5, 8, 1'b1, 1'b0);
      push_word(1'b1, 8'h3C, 8, 1'b0, 1'b0);
      push_word(1'b1, fault ? 8'hAD : 8'hA5, 8, 1'b0, 1'b1);
      push_word(1'b1, 8'h3C, 8, 1'b0, 1'b1);
      if (fault) begin
         fault_at  = b_en_cnt + 19;
         fault_arm = 1'b1;
      end
      pulse_start(1'b1);
      chk({nm, "_err_cleared"}, 32'(b_err), 32'd0);
      send_word(1'b1, 8'hA5);
      if (with_gap) begin
         b_valid = 1'b0;
         repeat (4) @(negedge clk);
         pulse_start(1'b1);
         repeat (5) @(negedge clk);
      end
      send_word(1'b1, 8'h3C);
      b_valid = 1'b0;
      wait_idle(1'b1, nm);
      fault_arm = 1'b0;
      chk({nm, "_cfg_cycles"}, 32'(b_cfg_cnt - c0), 32'd32);
      chk({nm, "_idle_busy"}, 32'(b_gap_cnt - g0), 32'(exp_gap));
      chk({nm, "_done"}, 32'(b_done_cnt - d0), 32'd1);
      chk({nm, "_chain"}, 32'(chain_b), 32'(exp_chain));
      chk({nm, "_crc_error"}, 32'(b_err), 32'(exp_err));
      chk({nm, "_queue_left"}, 32'(exp_b.size()), 32'd0);
   endtask

   initial begin
      int c0, d0;
      repeat (3) @(negedge clk);
      chk("a_reset_outputs", 32'({a_head, a_cfg, a_rdy, a_busy, a_done, a_err}), 32'd0);
      chk("b_reset_outputs", 32'({b_head, b_cfg, b_rdy, b_busy, b_done, b_err}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 5-flop chain, no verify: only the low 5 bits of 8'h15 are used.
      c0 = a_cfg_cnt; d0 = a_done_cnt;
      push_word(1'b0, 8'h15, 5, 1'b0, 1'b0);
      pulse_start(1'b0);
      send_word(1'b0, 8'h15);
      a_valid = 1'b0;
      wait_idle(1'b0, "a_load");
      chk("a_cfg_cycles", 32'(a_cfg_cnt - c0), 32'd5);
      chk("a_done", 32'(a_done_cnt - d0), 32'd1);
      chk("a_chain", 32'(chain_a), 32'h15);
      chk("a_crc_error", 32'(a_err), 32'd0);
      chk("a_queue_left", 32'(exp_a.size()), 32'd0);

      // Back-to-back words, clean verify.
      b_full_run("b_contig", 1'b0, 1'b0, 16'hA53C, 1'b0, 2);

      // Fault during VERIFY: bit 3 of the rotation comes back inverted.
      b_full_run("b_fault", 1'b0, 1'b1, 16'hB53C, 1'b1, 2);
      repeat (5) @(negedge clk);
      chk("b_err_sticky", 32'(b_err), 32'd1);

      // 3-cycle valid gap with an ignored start inside LOAD.
      b_full_run("b_gap", 1'b1, 1'b0, 16'hA53C, 1'b0, 5);

      // Reset while bit 7 is being shifted.
      c0 = b_cfg_cnt; d0 = b_done_cnt;
      push_word(1'b1, 8'hA5, 8, 1'b1, 1'b0);
      pulse_start(1'b1);
      send_word(1'b1, 8'hA5);
      b_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_cfg", 32'(b_cfg), 32'd0);
      chk("rst_busy", 32'(b_busy), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_no_done", 32'(b_done_cnt - d0), 32'd0);
      chk("rst_cfg_cycles", 32'(b_cfg_cnt - c0), 32'd8);
      chk("rst_queue_left", 32'(exp_b.size()), 32'd0);

      b_full_run("b_after_rst", 1'b0, 1'b0, 16'hA53C, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1);
   end

endmodule
